// File: rtl/grf_wb_sink_if.sv
// ----------------------------------------------------------------------------
// grf_wb_sink_if
//   Bundles the general register file's read ports, the write-back triple
//   coming from the write-back pipeline register, and the commit bookkeeping
//   outputs.
//
//   Signals (named after the register file's own port names):
//     I_A1, I_A2   read addresses            (master -> slave)
//     O_RD1, O_RD2 read data                 (slave  -> master)
//     I_A3, I_W1   write address / data      (master -> slave)
//     I_gwe        write enable              (master -> slave)
//     O_wcnt       committed write count     (slave  -> master)
//     O_lastA      last committed address    (slave  -> master)
//     O_lastD      last committed data       (slave  -> master)
//
//   Write-back handshake: I_gwe is the valid qualifier of the triple
//   (I_A3, I_W1); there is no ready, the file accepts every cycle. A triple
//   with I_gwe=1 and I_A3!=0 present at a rising edge outside reset is a
//   commit; with I_gwe=0 the address and data are ignored.
//
//   Parameters must match those of the grf_wb_sink instance bound to it.
// ----------------------------------------------------------------------------
interface grf_wb_sink_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] I_A1;
  logic [ADDR_W-1:0] I_A2;
  logic [DATA_W-1:0] O_RD1;
  logic [DATA_W-1:0] O_RD2;
  logic [ADDR_W-1:0] I_A3;
  logic [DATA_W-1:0] I_W1;
  logic              I_gwe;
  logic [CNT_W-1:0]  O_wcnt;
  logic [ADDR_W-1:0] O_lastA;
  logic [DATA_W-1:0] O_lastD;

  modport master (
    output I_A1, I_A2, I_A3, I_W1, I_gwe,
    input  O_RD1, O_RD2, O_wcnt, O_lastA, O_lastD
  );

  modport slave (
    input  I_A1, I_A2, I_A3, I_W1, I_gwe,
    output O_RD1, O_RD2, O_wcnt, O_lastA, O_lastD
  );
endinterface

// File: rtl/grf_wb_sink.sv
// ----------------------------------------------------------------------------
// grf_wb_sink
//   General register file at the consuming end of the write-back pipeline
//   register. Commits the write-back triple on the rising edge, serves two
//   combinational read ports, and keeps a commit counter plus the last
//   committed address/data for debug.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high; clears all entries and bookkeeping
//     bus    grf_wb_sink_if.slave (read ports, write-back triple, bookkeeping)
//
//   Configuration macro:
//     GRF_BYPASS_EN  when defined, a read whose address matches a pending
//                    commit returns I_W1 in the same cycle. When undefined,
//                    reads return stored contents only.
//
//   Entry 0 is hardwired to zero: writes to it are dropped without touching
//   the counter or the last-write registers. The counter wraps modulo
//   2**CNT_W.
// ----------------------------------------------------------------------------
module grf_wb_sink #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  grf_wb_sink_if.slave     bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [CNT_W-1:0]  wcnt_q,   wcnt_d;
  logic [ADDR_W-1:0] last_a_q, last_a_d;
  logic [DATA_W-1:0] last_d_q, last_d_d;
  logic              commit;
  logic [DATA_W-1:0] rd1, rd2;

  // A write to address 0 is not a commit at all, so the bookkeeping ignores it.
  assign commit = bus.I_gwe && (bus.I_A3 != '0);

  always_comb begin
    wcnt_d   = wcnt_q + CNT_W'(1);
    last_a_d = bus.I_A3;
    last_d_d = bus.I_W1;
  end

  // Entry 0 is never written, so its reset value of zero holds forever.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      wcnt_q   <= '0;
      last_a_q <= '0;
      last_d_q <= '0;
    end else if (commit) begin
      regs_q[bus.I_A3] <= bus.I_W1;
      wcnt_q           <= wcnt_d;
      last_a_q         <= last_a_d;
      last_d_q         <= last_d_d;
    end
  end

`ifdef GRF_BYPASS_EN
  // Forwarding is suppressed while reset is high: the write will be lost,
  // so showing its data would expose a value that never lands.
  logic fwd;
  assign fwd = commit && !reset;
`endif

  always_comb begin
    rd1 = '0;
    if (bus.I_A1 != '0) rd1 = regs_q[bus.I_A1];
`ifdef GRF_BYPASS_EN
    if (fwd && (bus.I_A1 == bus.I_A3)) rd1 = bus.I_W1;
`endif
  end

  always_comb begin
    rd2 = '0;
    if (bus.I_A2 != '0) rd2 = regs_q[bus.I_A2];
`ifdef GRF_BYPASS_EN
    if (fwd && (bus.I_A2 == bus.I_A3)) rd2 = bus.I_W1;
`endif
  end

  assign bus.O_RD1   = rd1;
  assign bus.O_RD2   = rd2;
  assign bus.O_wcnt  = wcnt_q;
  assign bus.O_lastA = last_a_q;
  assign bus.O_lastD = last_d_q;

endmodule

// File: tb/tb_grf_wb_sink.sv
// ----------------------------------------------------------------------------
// tb_grf_wb_sink
//   Directed plus randomized checks of grf_wb_sink against a reference model
//   made of a plain array, an integer counter and two "last write" variables.
//   Build with or without GRF_BYPASS_EN; the model follows the same macro.
// ----------------------------------------------------------------------------
module tb_grf_wb_sink;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  grf_wb_sink_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  grf_wb_sink #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] mem [32];
  int                m_cnt;
  logic [ADDR_W-1:0] m_last_a;
  logic [DATA_W-1:0] m_last_d;

  int vectors     = 0;
  int miscompares = 0;

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) mem[i] = '0;
    m_cnt    = 0;
    m_last_a = '0;
    m_last_d = '0;
  endfunction

  // What a read port should show right now, from the architectural rules.
  function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] a);
    if (reset === 1'b1) return '0;
    if (a == 0) return '0;
`ifdef GRF_BYPASS_EN
    if (bus.I_gwe && bus.I_A3 != 0 && a == bus.I_A3) return bus.I_W1;
`endif
    return mem[a];
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reads(input string tag);
    #1;
    check({tag, "_rd1"}, 64'(bus.O_RD1), 64'(exp_rd(bus.I_A1)));
    check({tag, "_rd2"}, 64'(bus.O_RD2), 64'(exp_rd(bus.I_A2)));
  endtask

  task automatic check_book(input string tag);
    #1;
    check({tag, "_wcnt"},  64'(bus.O_wcnt),  64'(m_cnt));
    check({tag, "_lastA"}, 64'(bus.O_lastA), 64'(m_last_a));
    check({tag, "_lastD"}, 64'(bus.O_lastD), 64'(m_last_d));
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge; the model commits on the rising edge.
  task automatic do_cycle();
    logic take;
    take = (reset === 1'b0) && bus.I_gwe && (bus.I_A3 != 0);
    @(posedge clk);
    if (take) begin
      mem[bus.I_A3] = bus.I_W1;
      m_cnt         = (m_cnt + 1) % 65536;
      m_last_a      = bus.I_A3;
      m_last_d      = bus.I_W1;
    end
    @(negedge clk);
  endtask

  task automatic drive_write(input logic we, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d);
    bus.I_gwe = we;
    bus.I_A3  = a;
    bus.I_W1  = d;
  endtask

  task automatic drive_reads(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
    bus.I_A1 = a1;
    bus.I_A2 = a2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    drive_write(1'b0, '0, '0);
    drive_reads('0, '0);
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state
    drive_reads(5'd1, 5'd31);
    check_reads("rst_init");
    check_book("rst_init");
    reset = 1'b0;
    do_cycle();

    // Preload 1..31 with all-ones, then pulse reset between edges
    for (int i = 1; i < 32; i++) begin
      drive_write(1'b1, 5'(i), 32'hFFFF_FFFF);
      do_cycle();
    end
    drive_write(1'b0, '0, '0);
    drive_reads(5'd17, 5'd31);
    check_reads("preload");
    check_book("preload");
    #2;
    reset = 1'b1;
    model_clear();
    for (int i = 0; i < 32; i += 2) begin
      drive_reads(5'(i), 5'(i + 1));
      check_reads("rst_pulse");
    end
    check_book("rst_pulse");
    @(negedge clk);
    reset = 1'b0;
    do_cycle();

    // Basic write/read
    drive_write(1'b1, 5'd5, 32'h1234_5678);
    do_cycle();
    drive_write(1'b0, '0, '0);
    drive_reads(5'd5, 5'd6);
    check_reads("basic");
    check("basic_rd1_const", 64'(bus.O_RD1), 64'h1234_5678);
    check_book("basic");

    // Zero register
    drive_write(1'b1, 5'd0, 32'hDEAD_BEEF);
    drive_reads(5'd0, 5'd0);
    check_reads("zero_pre");
    do_cycle();
    drive_write(1'b0, '0, '0);
    check_reads("zero_post");
    check_book("zero_post");

    // Same-cycle read of the address being written
    drive_write(1'b1, 5'd7, 32'h1);
    do_cycle();
    drive_write(1'b1, 5'd7, 32'h2);
    drive_reads(5'd7, 5'd7);
    check_reads("bypass_pre");
    do_cycle();
    drive_write(1'b0, '0, '0);
    check_reads("bypass_post");
    check_book("bypass_post");

    // Write enable low: no commit, no forwarding
    drive_write(1'b1, 5'd9, 32'h0000_0099);
    do_cycle();
    drive_write(1'b0, 5'd9, 32'hAAAA_AAAA);
    drive_reads(5'd9, 5'd9);
    check_reads("we_low_pre");
    do_cycle();
    check_reads("we_low_post");
    check_book("we_low_post");

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      drive_write(1'($urandom_range(1)), 5'($urandom_range(31)), $urandom);
      drive_reads(5'($urandom_range(31)), 5'($urandom_range(31)));
      if ($urandom_range(3) == 0) drive_reads(bus.I_A3, 5'($urandom_range(31)));
      check_reads("rand_pre");
      do_cycle();
      check_reads("rand_post");
      check_book("rand_post");
    end

    // Counter wrap
    while (m_cnt != 65535) begin
      drive_write(1'b1, 5'($urandom_range(31, 1)), $urandom);
      do_cycle();
    end
    drive_write(1'b0, '0, '0);
    check_book("cnt_ffff");
    drive_write(1'b1, 5'd3, 32'h0BAD_CAFE);
    do_cycle();
    drive_write(1'b0, '0, '0);
    check_book("cnt_wrap");
    check("cnt_wrap_zero", 64'(bus.O_wcnt), 64'd0);

    // Reset collides with a write to address 3
    drive_write(1'b1, 5'd3, 32'h3333_3333);
    drive_reads(5'd3, 5'd3);
    reset = 1'b1;
    model_clear();
    check_reads("collide_rst");
    do_cycle();
    check_reads("collide_edge");
    check_book("collide_edge");
    reset = 1'b0;
    drive_write(1'b0, '0, '0);
    do_cycle();
    check_reads("collide_after");
    check_book("collide_after");

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
